alarm_ringer: RTL and testbench



---
 rtl/alarm_ringer.sv | 159 +++++++++++++++
 tb/tb_alarm_ringer.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alarm_ringer.sv
// Alarm ringer: watches the running time against the stored alarm time and
// drives a buzzer tone for a bounded ring period, with stop and snooze keys.
module alarm_ringer #(
    parameter int RING_SECONDS   = 60,
    parameter int SNOOZE_MINUTES = 5,
    parameter int TONE_DIV       = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       second_tick,
    input  logic       alarm_enable,
    input  logic       stop_key,
    input  logic       snooze_key,
    input  logic [5:0] cur_hour,
    input  logic [5:0] cur_minute,
    input  logic [5:0] cur_second,
    input  logic [5:0] alm_hour,
    input  logic [5:0] alm_minute,
    input  logic [5:0] alm_second,
    output logic       ringing,
    output logic       snoozed,
    output logic       buzzer
);

    localparam int SNZ_TICKS = SNOOZE_MINUTES * 60;
    localparam int RW = (RING_SECONDS > 1) ? $clog2(RING_SECONDS) : 1;
    localparam int SW = (SNZ_TICKS > 1) ? $clog2(SNZ_TICKS) : 1;
    localparam int TW = (TONE_DIV > 1) ? $clog2(TONE_DIV) : 1;

    localparam logic [RW-1:0] RING_LAST = RW'(RING_SECONDS - 1);
    localparam logic [SW-1:0] SNZ_LAST  = SW'(SNZ_TICKS - 1);
    localparam logic [TW-1:0] TONE_LAST = TW'(TONE_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RING   = 2'd1,
        S_SNOOZE = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [RW-1:0] ring_cnt_q, ring_cnt_d;
    logic [SW-1:0] snz_cnt_q, snz_cnt_d;
    logic [TW-1:0] tone_cnt_q, tone_cnt_d;
    logic          buzzer_q, buzzer_d;
    logic          ringing_q, ringing_d;
    logic          snoozed_q, snoozed_d;
    logic          match_q, stop_q, snooze_q;

    logic match;
    logic match_rise;
    logic stop_rise;
    logic snooze_rise;

    assign match = (cur_hour == alm_hour) && (cur_minute == alm_minute) &&
                   (cur_second == alm_second);

    // match_q resets high so a time already matching at reset release is not a new match.
    assign match_rise  = match & ~match_q;
    assign stop_rise   = stop_key & ~stop_q;
    assign snooze_rise = snooze_key & ~snooze_q;

    always_comb begin
        state_d    = state_q;
        ring_cnt_d = ring_cnt_q;
        snz_cnt_d  = snz_cnt_q;
        tone_cnt_d = tone_cnt_q;
        buzzer_d   = buzzer_q;

        case (state_q)
            S_IDLE: begin
                if (match_rise) begin
                    state_d    = S_RING;
                    ring_cnt_d = '0;
                end
            end
            S_RING: begin
                if (stop_rise) begin
                    state_d = S_IDLE;
                end else if (snooze_rise) begin
                    state_d   = S_SNOOZE;
                    snz_cnt_d = '0;
                end else if (second_tick) begin
                    if (ring_cnt_q == RING_LAST) begin
                        state_d = S_IDLE;
                    end else begin
                        ring_cnt_d = ring_cnt_q + RW'(1);
                    end
                end
            end
            S_SNOOZE: begin
                // A key edge on a tick cycle consumes the tick.
                if (stop_rise) begin
                    state_d = S_IDLE;
                end else if (second_tick) begin
                    if (snz_cnt_q == SNZ_LAST) begin
                        state_d    = S_RING;
                        ring_cnt_d = '0;
                    end else begin
                        snz_cnt_d = snz_cnt_q + SW'(1);
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (!alarm_enable) begin
            state_d = S_IDLE;
        end

        // Tone only runs while staying in RING; entering or leaving restarts it silent.
        if ((state_q == S_RING) && (state_d == S_RING)) begin
            if (tone_cnt_q == TONE_LAST) begin
                tone_cnt_d = '0;
                buzzer_d   = ~buzzer_q;
            end else begin
                tone_cnt_d = tone_cnt_q + TW'(1);
            end
        end else begin
            tone_cnt_d = '0;
            buzzer_d   = 1'b0;
        end

        ringing_d = (state_d == S_RING);
        snoozed_d = (state_d == S_SNOOZE);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            ring_cnt_q <= '0;
            snz_cnt_q  <= '0;
            tone_cnt_q <= '0;
            buzzer_q   <= 1'b0;
            ringing_q  <= 1'b0;
            snoozed_q  <= 1'b0;
            match_q    <= 1'b1;
            stop_q     <= 1'b0;
            snooze_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            ring_cnt_q <= ring_cnt_d;
            snz_cnt_q  <= snz_cnt_d;
            tone_cnt_q <= tone_cnt_d;
            buzzer_q   <= buzzer_d;
            ringing_q  <= ringing_d;
            snoozed_q  <= snoozed_d;
            match_q    <= match;
            stop_q     <= stop_key;
            snooze_q   <= snooze_key;
        end
    end

    assign ringing = ringing_q;
    assign snoozed = snoozed_q;
    assign buzzer  = buzzer_q;

endmodule

// File: tb/tb_alarm_ringer.sv
// Randomised and directed bench for alarm_ringer: a driver pushes expected
// {ringing,snoozed,buzzer} per cycle from a countdown model; a monitor pops and compares.
module tb_alarm_ringer;

    localparam int RING_SECONDS   = 4;
    localparam int SNOOZE_MINUTES = 1;
    localparam int TONE_DIV       = 2;
    localparam int TICK_PERIOD    = 10;
    localparam int SNZ_TICKS      = SNOOZE_MINUTES * 60;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       second_tick = 1'b0;
    logic       alarm_enable = 1'b0;
    logic       stop_key = 1'b0;
    logic       snooze_key = 1'b0;
    logic [5:0] cur_hour = '0, cur_minute = '0, cur_second = '0;
    logic [5:0] alm_hour = '0, alm_minute = '0, alm_second = '0;
    logic       ringing, snoozed, buzzer;

    alarm_ringer #(
        .RING_SECONDS  (RING_SECONDS),
        .SNOOZE_MINUTES(SNOOZE_MINUTES),
        .TONE_DIV      (TONE_DIV)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .second_tick (second_tick),
        .alarm_enable(alarm_enable),
        .stop_key    (stop_key),
        .snooze_key  (snooze_key),
        .cur_hour    (cur_hour),
        .cur_minute  (cur_minute),
        .cur_second  (cur_second),
        .alm_hour    (alm_hour),
        .alm_minute  (alm_minute),
        .alm_second  (alm_second),
        .ringing     (ringing),
        .snoozed     (snoozed),
        .buzzer      (buzzer)
    );

    always #5 clock = ~clock;

    logic [2:0] exp_q[$];
    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int tick_phase = 0;
    bit running = 1'b1;

    // Reference model: mode 0 idle, 1 ringing, 2 snoozing; seconds left counted down.
    int m_mode = 0;
    int m_ring_left = 0;
    int m_snz_left = 0;
    int m_age = 0;
    bit m_prev_match = 1'b1;
    bit m_prev_stop = 1'b0;
    bit m_prev_snz = 1'b0;

    task automatic check(input string name, input logic [2:0] act, input logic [2:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d actual(ring,snz,buz)=%b expected=%b", name, cyc, act, exp);
        end
    endtask

    task automatic model_step(output logic [2:0] e);
        bit match, mr, sr, zr;
        int old;
        if (!reset) begin
            m_mode = 0;
            m_age = 0;
            m_prev_match = 1'b1;
            m_prev_stop = 1'b0;
            m_prev_snz = 1'b0;
            e = 3'b000;
            return;
        end
        match = ({cur_hour, cur_minute, cur_second} == {alm_hour, alm_minute, alm_second});
        mr = match && !m_prev_match;
        sr = stop_key && !m_prev_stop;
        zr = snooze_key && !m_prev_snz;
        old = m_mode;
        if (!alarm_enable) begin
            m_mode = 0;
        end else begin
            case (m_mode)
                0: if (mr) begin
                    m_mode = 1;
                    m_ring_left = RING_SECONDS;
                    m_age = 0;
                end
                1: if (sr) m_mode = 0;
                   else if (zr) begin
                       m_mode = 2;
                       m_snz_left = SNZ_TICKS;
                   end else if (second_tick) begin
                       m_ring_left--;
                       if (m_ring_left == 0) m_mode = 0;
                   end
                default: if (sr) m_mode = 0;
                   else if (second_tick) begin
                       m_snz_left--;
                       if (m_snz_left == 0) begin
                           m_mode = 1;
                           m_ring_left = RING_SECONDS;
                           m_age = 0;
                       end
                   end
            endcase
        end
        if (old == 1 && m_mode == 1) m_age++;
        m_prev_match = match;
        m_prev_stop = stop_key;
        m_prev_snz = snooze_key;
        e = {m_mode == 1, m_mode == 2, (m_mode == 1) && ((m_age / TONE_DIV) % 2 == 1)};
    endtask

    // Inputs are applied before the call; the expectation covers the next rising edge.
    task automatic cycle();
        logic [2:0] e;
        second_tick = (tick_phase == TICK_PERIOD - 1);
        tick_phase = (tick_phase + 1) % TICK_PERIOD;
        model_step(e);
        exp_q.push_back(e);
        @(negedge clock);
        cyc++;
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic set_cur(input int h, input int m, input int s);
        cur_hour = 6'(h);
        cur_minute = 6'(m);
        cur_second = 6'(s);
    endtask

    task automatic trigger();
        set_cur(7, 29, 59);
        run(3);
        set_cur(7, 30, 0);
        cycle();
    endtask

    task automatic press_stop();
        stop_key = 1'b1;
        cycle();
        stop_key = 1'b0;
        cycle();
    endtask

    task automatic press_snooze();
        snooze_key = 1'b1;
        cycle();
        snooze_key = 1'b0;
        cycle();
    endtask

    task automatic reset_now();
        #2 reset = 1'b0;
        #1 check("async_reset", {ringing, snoozed, buzzer}, 3'b000);
        cycle();
    endtask

    initial begin : monitor
        logic [2:0] e;
        forever begin
            @(posedge clock);
            #1;
            if (!running) break;
            if (exp_q.size() == 0) begin
                check("no_expectation", {ringing, snoozed, buzzer}, 3'bxxx);
            end else begin
                e = exp_q.pop_front();
                check("outputs", {ringing, snoozed, buzzer}, e);
            end
        end
    end

    initial begin : watchdog
        #2000000;
        failures++;
        $display("FAIL watchdog cycle=%0d actual=timeout expected=finish", cyc);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

    initial begin : driver
        int r;
        alm_hour = 6'd7;
        alm_minute = 6'd30;
        alm_second = 6'd0;
        set_cur(7, 30, 0);
        alarm_enable = 1'b1;
        reset = 1'b0;
        run(3);
        reset = 1'b1;
        run(20);

        trigger();
        run(50);

        trigger();
        run(6);
        press_stop();
        run(30);

        trigger();
        run(5);
        press_snooze();
        run(SNZ_TICKS * TICK_PERIOD + 60);

        trigger();
        run(7);
        press_snooze();
        run(25);
        press_stop();
        run(10);

        trigger();
        run(3);
        while (tick_phase != TICK_PERIOD - 1) cycle();
        snooze_key = 1'b1;
        cycle();
        snooze_key = 1'b0;
        run(12);
        press_stop();
        run(5);

        trigger();
        run(5);
        stop_key = 1'b1;
        snooze_key = 1'b1;
        cycle();
        stop_key = 1'b0;
        snooze_key = 1'b0;
        run(10);

        trigger();
        run(5);
        alarm_enable = 1'b0;
        run(5);
        alarm_enable = 1'b1;
        run(20);

        alarm_enable = 1'b0;
        set_cur(7, 29, 59);
        run(3);
        set_cur(7, 30, 0);
        run(10);
        alarm_enable = 1'b1;
        run(20);

        alarm_enable = 1'b0;
        set_cur(7, 29, 59);
        run(3);
        set_cur(7, 30, 0);
        alarm_enable = 1'b1;
        run(50);

        trigger();
        run(4);
        press_snooze();
        run(20);
        reset_now();
        run(2);
        reset = 1'b1;
        run(5);
        trigger();
        run(50);

        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 99);
            if (r < 3) set_cur(7, 30, 0);
            else if (r < 6) set_cur(7, 29, 59);
            else if (r < 8) set_cur($urandom_range(0, 23), $urandom_range(0, 59), $urandom_range(0, 59));
            stop_key = ($urandom_range(0, 59) == 0);
            snooze_key = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 149) == 0) alarm_enable = ~alarm_enable;
            cycle();
        end

        running = 1'b0;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL leftover_expectations actual=%0d expected=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
